key_event_queue: RTL and testbench
==================================

Name: key_event_queue

Overview:
- Sits directly downstream of the keypad/digital-input debouncer and consumes its 4-bit key code and its active ("any key") line.
- Turns key activity into discrete press events and queues them in a small FIFO, with auto-repeat while a key is held.
- Presents the queue to the host processor through a simple synchronous read port, and raises a level interrupt while events are pending.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of 2, minimum 2.
- REPEAT_DELAY, 25000000, clock cycles a key must be held before the first repeat event.
- REPEAT_RATE, 5000000, clock cycles between subsequent repeat events.
- CNT_BITS, 25, width of the repeat counter; must hold max(REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- key_code  input  4  code from the debouncer; valid one cycle after key_active rises.
- key_active  input  1  OR of all debounced inputs from the debouncer.
- rd_en  input  1  host read strobe; pops one entry.
- clr  input  1  flushes the FIFO and clears the overflow flag.
- rd_data  output  8  {overflow, repeat_flag, 2'b00, code[3:0]}.
- rd_valid  output  1  one-cycle pulse; rd_data is valid.
- count  output  $clog2(DEPTH)+1  number of entries held.
- irq  output  1  high while count != 0.

Behaviour:
- One clock; reset is synchronous and active-low; all state is updated on posedge clk.
- Reset: FIFO empty, overflow=0, rd_data=0, rd_valid=0, count=0, irq=0, FSM=IDLE.
- key_active is registered once (ka_q) for edge detection. A rise is key_active=1 && ka_q=0.
- Event FSM:
  - IDLE: on a rise -> CAPTURE.
  - CAPTURE: lasts exactly 1 cycle. Sample key_code, push {repeat=0, code}, load the counter with REPEAT_DELAY-1 -> HELD.
  - HELD:
    - key_active=0 -> IDLE.
    - Counter reaches 0 -> push {repeat=1, last code}, reload the counter with REPEAT_RATE-1, stay in HELD.
    - A change in key_code while held does not start a new press event. Repeats keep using the code sampled in CAPTURE.
- Press-to-enqueue latency: the entry becomes visible (count increments) 2 cycles after the key_active rise.
- A key_active drop during CAPTURE does not cancel the capture: the event is still pushed, then the FSM goes to IDLE.
- FIFO is first-in first-out with wrap-around pointers of $clog2(DEPTH) bits plus one extra bit for full/empty.
- Push when full: the entry is dropped, overflow is set (sticky), and FIFO contents are unchanged.
- rd_en when not empty: rd_data is loaded from the head and rd_valid is pulsed in the next cycle.
  - rd_data[7] carries the overflow flag at the time of the read.
- rd_en when empty: rd_valid stays 0, rd_data holds its previous value, and there is no error.
- Push and pop in the same cycle:
  - Not full: both happen and count is unchanged.
  - Full: the pop happens first, the push succeeds, and overflow is not set.
  - Empty: only the push happens, and rd_valid stays 0.
- clr:
  - Pointers, count and overflow return to 0 next cycle; rd_valid=0.
  - The FSM is not reset, so an event pushed in the same cycle as clr is discarded.
  - clr has priority over rd_en and over a push.
- irq is registered from the next-state count and equals (count != 0) in the same cycle.
- Reset asserted mid-operation, including a held key: everything returns to reset values. After reset is released, a key that is still held needs a fresh rise, so no event is generated until key_active goes low and then high again.

Decomposition:
- Package key_event_pkg holds:
  - rd_data field positions (OVF_BIT=7, RPT_BIT=6, CODE_LSB=0, CODE_W=4);
  - the FSM state encoding (IDLE, CAPTURE, HELD);
  - default timing constants.
- Sub-module sync_fifo (parameterised WIDTH and DEPTH; provides push, pop, clr, full, empty, count).
- key_event_queue contains the edge detect, the FSM, the repeat counter, the overflow flag and the read register.

Test Plan:
- Reset, then press code 4'hA for 100 cycles with REPEAT_DELAY=1000 -> one entry; irq=1 at cycle 2; rd_en -> rd_data=8'h0A, rd_valid pulse; then irq=0.
- Hold code 4'h5 with REPEAT_DELAY=50, REPEAT_RATE=20 for 100 cycles -> entries 8'h05, 8'h45, 8'h45, 8'h45 (repeats at +52, +72, +92 after the rise).
- With DEPTH=8, issue 10 distinct presses without reading -> count=8; drain gives the first 8 codes in order, each with bit 7=1.
- With the FIFO full, assert rd_en in the same cycle as a new press capture -> count stays 8, overflow stays 0, and the newest code appears last on drain.
- With 3 entries queued, assert clr -> count=0, irq=0 next cycle; rd_en -> no rd_valid.
- Assert reset during HELD with the key still down -> no further events; release reset; an event appears only after key_active falls and rises again.

Source files
------------

// File: rtl/key_event_queue_pkg.sv
// Shared definitions for the key event queue: read-word layout, event FSM
// encoding and default timing constants.
package key_event_pkg;

  // rd_data field positions
  localparam int OVF_BIT  = 7;
  localparam int RPT_BIT  = 6;
  localparam int CODE_LSB = 0;
  localparam int CODE_W   = 4;

  // A queued entry is {repeat_flag, code}
  localparam int ENTRY_W  = CODE_W + 1;

  // Default timing / sizing
  localparam int DEF_DEPTH        = 8;
  localparam int DEF_REPEAT_DELAY = 25000000;
  localparam int DEF_REPEAT_RATE  = 5000000;
  localparam int DEF_CNT_BITS     = 25;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  // Build the host-visible read word from the overflow flag and a queue entry.
  function automatic logic [7:0] pack_rd_data(input logic ovf,
                                              input logic [ENTRY_W-1:0] entry);
    logic [7:0] d;
    d = '0;
    d[OVF_BIT] = ovf;
    d[RPT_BIT] = entry[CODE_W];
    d[CODE_LSB +: CODE_W] = entry[CODE_W-1:0];
    return d;
  endfunction

endpackage

// File: rtl/key_event_queue_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers carrying one extra bit to tell
// full from empty. A push while full is accepted only if a pop frees a slot
// in the same cycle; clr empties the FIFO and overrides push and pop.
module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clr,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [$clog2(DEPTH):0]   o_count_nxt
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW:0]      w_wr_nxt;
  logic [AW:0]      w_rd_nxt;

  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count     = r_wr_ptr - r_rd_ptr;
  assign o_count_nxt = w_wr_nxt - w_rd_nxt;
  assign o_data      = r_mem[r_rd_ptr[AW-1:0]];

  // Next pointer values; pop frees a slot before the push is considered.
  always_comb begin
    w_do_pop  = i_pop && !o_empty;
    w_do_push = i_push && (!o_full || w_do_pop);
    w_wr_nxt  = r_wr_ptr + (AW+1)'(w_do_push);
    w_rd_nxt  = r_rd_ptr + (AW+1)'(w_do_pop);
    if (i_clr) begin
      w_wr_nxt = '0;
      w_rd_nxt = '0;
    end
  end

  // Pointer registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced key activity into press / auto-repeat events, queues them
// and exposes them to the host through a strobed read port and a level irq.
// Host port handshake: rd_en is a request with no back-pressure; when the
// queue is non-empty the head is popped and rd_valid pulses for exactly one
// cycle together with rd_data. A request on an empty queue is ignored.
module key_event_queue
  import key_event_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int CNT_BITS     = DEF_CNT_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CODE_W-1:0]      key_code,
  input  logic                   key_active,
  input  logic                   rd_en,
  input  logic                   clr,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   irq,
  output logic [1:0]             dbg_state
);
  state_t               r_state;
  logic                 r_ka_q;
  logic [CNT_BITS-1:0]  r_cnt;
  logic [CODE_W-1:0]    r_code;
  logic                 r_overflow;
  logic [7:0]           r_rd_data;
  logic                 r_rd_valid;
  logic                 r_irq;

  logic                 w_rise;
  logic                 w_push;
  logic [ENTRY_W-1:0]   w_push_data;
  logic                 w_pop;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_empty;
  logic [ENTRY_W-1:0]   w_head;
  logic [$clog2(DEPTH):0] w_count_nxt;

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign irq       = r_irq;
  assign dbg_state = r_state;

  // Event generation: capture pushes the live code, repeats reuse the held one.
  always_comb begin
    w_rise      = key_active && !r_ka_q;
    w_push      = 1'b0;
    w_push_data = {1'b1, r_code};
    if (r_state == ST_CAPTURE) begin
      w_push      = 1'b1;
      w_push_data = {1'b0, key_code};
    end else if (r_state == ST_HELD && key_active && r_cnt == '0) begin
      w_push = 1'b1;
    end
    w_pop  = rd_en && !w_empty && !clr;
    w_drop = w_push && w_full && !w_pop && !clr;
  end

  // Edge-detect register follows the input even through reset, so a key held
  // across reset shows no rise until it is released and pressed again.
  always_ff @(posedge clk) begin
    r_ka_q <= key_active;
  end

  // Event FSM with repeat counter and captured code.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_code  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_code  <= key_code;
          r_cnt   <= CNT_BITS'(REPEAT_DELAY - 1);
          r_state <= key_active ? ST_HELD : ST_IDLE;
        end
        ST_HELD: begin
          if (!key_active)      r_state <= ST_IDLE;
          else if (r_cnt == '0) r_cnt   <= CNT_BITS'(REPEAT_RATE - 1);
          else                  r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow: set when an event is dropped, cleared only by clr.
  always_ff @(posedge clk) begin
    if (!reset)      r_overflow <= 1'b0;
    else if (clr)    r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  // Read register: load the head on a successful pop, hold otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_pop) begin
      r_rd_data  <= pack_rd_data(r_overflow, w_head);
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  // irq tracks the count the FIFO will hold after this edge.
  always_ff @(posedge clk) begin
    if (!reset) r_irq <= 1'b0;
    else        r_irq <= (w_count_nxt != '0);
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_clr       (clr),
    .i_data      (w_push_data),
    .o_data      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (count),
    .o_count_nxt (w_count_nxt)
  );

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: a cycle table for single-press behaviour plus
// hand-written sequences for auto-repeat, overflow, full push/pop, clr and
// reset while a key is held.
module tb_key_event_queue;

  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_C = 2'd1;
  localparam logic [1:0] S_H = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_code;
  logic       key_active;
  logic       rd_en;
  logic       clr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] count;
  logic       irq;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic       ka;
    logic [3:0] code;
    logic       rd;
    logic       cl;
    logic [3:0] e_count;
    logic       e_irq;
    logic       e_valid;
    logic [7:0] e_data;
    logic [1:0] e_state;
  } vec_t;

  vec_t vecs[25];

  key_event_queue #(
    .DEPTH        (8),
    .REPEAT_DELAY (50),
    .REPEAT_RATE  (20),
    .CNT_BITS     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_code   (key_code),
    .key_active (key_active),
    .rd_en      (rd_en),
    .clr        (clr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .count      (count),
    .irq        (irq),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic press(input logic [3:0] c);
    key_active = 1'b1;
    key_code   = c;
    tick();
    tick();
    key_active = 1'b0;
    tick();
    tick();
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Scoreboard: pop n entries and compare against the expected queue.
  task automatic drain(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      tick();
      e = exp_q.pop_front();
      check("drain_valid", 32'(rd_valid), 32'd1);
      check("drain_data", 32'(rd_data), 32'(e));
    end
    rd_en = 1'b0;
    tick();
    check("drain_valid_end", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    // Row fields: ka, code, rd, clr | count, irq, rd_valid, rd_data, state
    vecs[0]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, S_I};
    vecs[1]  = '{1'b1, 4'hA, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, S_C};
    vecs[2]  = '{1'b1, 4'hA, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 8'h00, S_H};
    vecs[3]  = '{1'b0, 4'hA, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 8'h0A, S_I};
    vecs[4]  = '{1'b0, 4'hA, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'h0A, S_I};
    vecs[5]  = '{1'b1, 4'h3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h0A, S_C};
    vecs[6]  = '{1'b0, 4'h3, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 8'h0A, S_I};
    vecs[7]  = '{1'b1, 4'h7, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 8'h0A, S_C};
    vecs[8]  = '{1'b1, 4'h7, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 8'h0A, S_H};
    vecs[9]  = '{1'b1, 4'h9, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 8'h0A, S_H};
    vecs[10] = '{1'b0, 4'h9, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 8'h0A, S_I};
    vecs[11] = '{1'b0, 4'h9, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 8'h03, S_I};
    vecs[12] = '{1'b1, 4'hC, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 8'h03, S_C};
    vecs[13] = '{1'b1, 4'hC, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 8'h03, S_H};
    vecs[14] = '{1'b0, 4'hC, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'h03, S_I};
    vecs[15] = '{1'b1, 4'h2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h03, S_C};
    vecs[16] = '{1'b0, 4'h2, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 8'h03, S_I};
    vecs[17] = '{1'b1, 4'h6, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 8'h03, S_C};
    vecs[18] = '{1'b0, 4'h6, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 8'h02, S_I};
    vecs[19] = '{1'b0, 4'h6, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 8'h06, S_I};
    vecs[20] = '{1'b0, 4'h6, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h06, S_I};
    vecs[21] = '{1'b1, 4'h1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h06, S_C};
    vecs[22] = '{1'b0, 4'h1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 8'h06, S_I};
    vecs[23] = '{1'b0, 4'h1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 8'h01, S_I};
    vecs[24] = '{1'b0, 4'h1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h01, S_I};

    // Reset
    reset = 1'b0; key_code = 4'h0; key_active = 1'b0; rd_en = 1'b0; clr = 1'b0;
    tick();
    tick();
    check("reset_count", 32'(count), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_valid", 32'(rd_valid), 32'd0);
    check("reset_data", 32'(rd_data), 32'h00);
    check("reset_state", 32'(dbg_state), 32'(S_I));
    reset = 1'b1;

    // Table-driven single-press behaviour
    for (int i = 0; i < 25; i++) begin
      key_active = vecs[i].ka;
      key_code   = vecs[i].code;
      rd_en      = vecs[i].rd;
      clr        = vecs[i].cl;
      tick();
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].e_irq));
      check($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].e_data));
      check($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(vecs[i].e_state));
    end
    rd_en = 1'b0;
    clr   = 1'b0;

    // Auto-repeat: press at +2, repeats at +52, +72, +92; code change ignored
    for (int i = 0; i < 100; i++) begin
      int e;
      key_active = 1'b1;
      key_code   = (i < 10) ? 4'h5 : 4'hE;
      tick();
      e = int'(i >= 1) + int'(i >= 51) + int'(i >= 71) + int'(i >= 91);
      check($sformatf("rpt_count_c%0d", i), 32'(count), 32'(e));
    end
    key_active = 1'b0;
    tick();
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h45);
    drain(4);

    // Overflow: 10 presses into 8 slots, sticky flag on every read
    for (int i = 0; i < 10; i++) press(4'(i));
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_irq", 32'(irq), 32'd1);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h80 | 8'(i));
    drain(8);
    check("ovf_count_after", 32'(count), 32'd0);
    check("ovf_irq_after", 32'(irq), 32'd0);

    // Full FIFO: pop in the same cycle as a capture keeps the push
    clr_pulse();
    for (int i = 8; i < 16; i++) press(4'(i));
    check("full_count", 32'(count), 32'd8);
    key_active = 1'b1;
    key_code   = 4'h3;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("fullpp_valid", 32'(rd_valid), 32'd1);
    check("fullpp_data", 32'(rd_data), 32'h08);
    check("fullpp_count", 32'(count), 32'd8);
    key_active = 1'b0;
    tick();
    for (int i = 9; i < 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h03);
    drain(8);

    // clr with three entries queued
    press(4'h1);
    press(4'h2);
    press(4'h3);
    check("clr_pre_count", 32'(count), 32'd3);
    clr_pulse();
    check("clr_count", 32'(count), 32'd0);
    check("clr_irq", 32'(irq), 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("clr_read_valid", 32'(rd_valid), 32'd0);

    // Reset while a key is held
    key_active = 1'b1;
    key_code   = 4'hB;
    repeat (5) tick();
    check("hold_count", 32'(count), 32'd1);
    check("hold_state", 32'(dbg_state), 32'(S_H));
    reset = 1'b0;
    tick();
    tick();
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);
    check("midrst_data", 32'(rd_data), 32'h00);
    check("midrst_state", 32'(dbg_state), 32'(S_I));
    reset = 1'b1;
    repeat (80) tick();
    check("held_after_rst_count", 32'(count), 32'd0);
    check("held_after_rst_state", 32'(dbg_state), 32'(S_I));
    key_active = 1'b0;
    tick();
    tick();
    key_active = 1'b1;
    key_code   = 4'hD;
    tick();
    tick();
    check("repress_count", 32'(count), 32'd1);
    key_active = 1'b0;
    tick();
    exp_q.push_back(8'h0D);
    drain(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
